// File: rtl/div_unit_pkg.sv
// Shared ALU control codes and divider state encoding for the execute stage.
package div_unit_pkg;

  localparam int ALU_CTRL_W = 6;

  localparam logic [ALU_CTRL_W-1:0] ALU_SIGNED_DIV   = 6'b011010;
  localparam logic [ALU_CTRL_W-1:0] ALU_UNSIGNED_DIV = 6'b011011;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic logic is_div_op(input logic [ALU_CTRL_W-1:0] ctrl);
    return (ctrl == ALU_SIGNED_DIV) || (ctrl == ALU_UNSIGNED_DIV);
  endfunction

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider: request seen in cycle T stalls T..T+WIDTH, result valid at T+WIDTH+1.
// Result is held in DONE while stallE_other is high; flushE aborts at any point.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flushE,
  input  logic                   stallE_other,
  input  logic [ALU_CTRL_W-1:0]  alu_controlE,
  input  logic [WIDTH-1:0]       src_aE,
  input  logic [WIDTH-1:0]       src_bE,
  output logic                   div_stallE,
  output logic                   div_readyE,
  output logic [2*WIDTH-1:0]     div_resultE
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  div_state_e           state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [WIDTH-1:0]     rem_q;
  logic [WIDTH-1:0]     dvd_q;
  logic [WIDTH-1:0]     dvs_q;
  logic                 neg_quo_q;
  logic                 neg_rem_q;
  logic                 ready_q;
  logic [2*WIDTH-1:0]   result_q;

  logic                 div_req;
  logic                 signed_req;
  logic                 a_neg;
  logic                 b_neg;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH:0]       trial;
  logic [WIDTH-1:0]     rem_d;
  logic [WIDTH-1:0]     dvd_d;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;

  always_comb begin
    div_req    = is_div_op(alu_controlE) && !flushE;
    signed_req = (alu_controlE == ALU_SIGNED_DIV);
    a_neg      = signed_req && src_aE[WIDTH-1];
    b_neg      = signed_req && src_bE[WIDTH-1];
    a_mag      = a_neg ? -src_aE : src_aE;
    b_mag      = b_neg ? -src_bE : src_bE;

    // Partial remainder stays below the divisor, so WIDTH bits hold it;
    // the shifted value needs one more, and that bit is the trial sign.
    rem_sh = {rem_q, dvd_q[WIDTH-1]};
    trial  = rem_sh - {1'b0, dvs_q};
    if (!trial[WIDTH]) begin
      rem_d = trial[WIDTH-1:0];
      dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = rem_sh[WIDTH-1:0];
      dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
    end

    quo_fix = neg_quo_q ? -dvd_d : dvd_d;
    rem_fix = neg_rem_q ? -rem_d : rem_d;

    div_stallE = ((state_q == DIV_IDLE) && div_req) || (state_q == DIV_BUSY);
  end

  always_ff @(posedge clk) begin
    if (rst || flushE) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      result_q  <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          ready_q <= 1'b0;
          if (div_req) begin
            rem_q     <= '0;
            dvd_q     <= a_mag;
            dvs_q     <= b_mag;
            // Divide-by-zero keeps an all-ones quotient; the remainder
            // fix-up alone turns |a| back into the raw dividend.
            neg_quo_q <= (a_neg ^ b_neg) && (src_bE != '0);
            neg_rem_q <= a_neg;
            cnt_q     <= '0;
            state_q   <= DIV_BUSY;
          end
        end
        DIV_BUSY: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q  <= DIV_DONE;
            ready_q  <= 1'b1;
            result_q <= {rem_fix, quo_fix};
          end
        end
        DIV_DONE: begin
          if (!stallE_other) begin
            state_q <= DIV_IDLE;
            ready_q <= 1'b0;
          end
        end
        default: begin
          state_q <= DIV_IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign div_readyE  = ready_q;
  assign div_resultE = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: driver pushes reference results, negedge monitor pops on ready.
module tb_div_unit;

  localparam logic [5:0] OP_SDIV = 6'b011010;
  localparam logic [5:0] OP_UDIV = 6'b011011;
  localparam logic [5:0] OP_NOP  = 6'd0;

  logic        clk = 1'b0;
  logic        rst;
  logic        flushE;
  logic        stallE_other;
  logic [5:0]  alu_controlE;
  logic [31:0] src_aE;
  logic [31:0] src_bE;
  logic        div_stallE;
  logic        div_readyE;
  logic [63:0] div_resultE;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];
  logic        prev_rdy = 1'b0;

  div_unit #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .flushE       (flushE),
    .stallE_other (stallE_other),
    .alu_controlE (alu_controlE),
    .src_aE       (src_aE),
    .src_bE       (src_bE),
    .div_stallE   (div_stallE),
    .div_readyE   (div_readyE),
    .div_resultE  (div_resultE)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer division with truncation toward zero.
  function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  always @(negedge clk) begin
    if (div_readyE && !prev_rdy) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ready", {63'd0, div_readyE}, 64'd0);
      end else begin
        chk("result", div_resultE, exp_q.pop_front());
      end
    end
    prev_rdy = div_readyE;
  end

  // Called just after a negedge; ends just after the negedge of the following IDLE cycle.
  task automatic do_div(input bit sgn, input logic [31:0] a, input logic [31:0] b, input int hold);
    int n;
    logic [63:0] e;
    e = model(sgn, a, b);
    exp_q.push_back(e);
    alu_controlE = sgn ? OP_SDIV : OP_UDIV;
    src_aE = a;
    src_bE = b;
    n = 0;
    #1;
    while (div_stallE && n < 200) begin
      n++;
      @(negedge clk); #1;
    end
    chk("stall_cycles", 64'(n), 64'd33);
    chk("ready_after_stall", {63'd0, div_readyE}, 64'd1);
    stallE_other = (hold > 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); #1;
      chk("hold_ready", {63'd0, div_readyE}, 64'd1);
      chk("hold_stall", {63'd0, div_stallE}, 64'd0);
      chk("hold_result", div_resultE, e);
      if (i == hold - 1) stallE_other = 1'b0;
    end
    alu_controlE = OP_NOP;
    @(negedge clk); #1;
    chk("idle_ready", {63'd0, div_readyE}, 64'd0);
    chk("idle_stall", {63'd0, div_stallE}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb;
    bit rs;
    rst = 1'b1;
    flushE = 1'b0;
    stallE_other = 1'b0;
    alu_controlE = OP_NOP;
    src_aE = '0;
    src_bE = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ready", {63'd0, div_readyE}, 64'd0);
    chk("reset_stall", {63'd0, div_stallE}, 64'd0);
    chk("reset_result", div_resultE, 64'd0);
    rst = 1'b0;
    @(negedge clk); #1;

    do_div(1'b0, 32'd7, 32'd2, 0);
    chk("model_7_2", model(1'b0, 32'd7, 32'd2), {32'd1, 32'd3});
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE, 0);
    do_div(1'b0, 32'hFFFF_FFF9, 32'd2, 0);
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_div(1'b0, 32'h0000_1234, 32'd0, 0);
    do_div(1'b1, 32'hFFFF_FF00, 32'd0, 0);

    // Flush at BUSY cycle 10: no result, stall drops the next cycle.
    alu_controlE = OP_UDIV;
    src_aE = 32'd1000;
    src_bE = 32'd3;
    repeat (11) @(negedge clk);
    #1;
    chk("flush_pre_stall", {63'd0, div_stallE}, 64'd1);
    flushE = 1'b1;
    alu_controlE = OP_NOP;
    @(negedge clk); #1;
    flushE = 1'b0;
    chk("flush_stall", {63'd0, div_stallE}, 64'd0);
    chk("flush_ready", {63'd0, div_readyE}, 64'd0);
    do_div(1'b0, 32'd100, 32'd7, 0);

    // Hold in DONE for 3 cycles, then a back-to-back divide.
    do_div(1'b1, 32'hFFFF_FF9C, 32'd7, 3);
    do_div(1'b0, 32'd12345, 32'd11, 0);

    // Reset mid-BUSY.
    alu_controlE = OP_SDIV;
    src_aE = 32'd500;
    src_bE = 32'd9;
    repeat (6) @(negedge clk);
    #1;
    rst = 1'b1;
    alu_controlE = OP_NOP;
    @(negedge clk); #1;
    chk("rst_mid_stall", {63'd0, div_stallE}, 64'd0);
    chk("rst_mid_ready", {63'd0, div_readyE}, 64'd0);
    chk("rst_mid_result", div_resultE, 64'd0);
    rst = 1'b0;
    @(negedge clk); #1;

    for (int k = 0; k < 24; k++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
        default: rb = $urandom;
      endcase
      do_div(rs, ra, rb, $urandom_range(0, 2));
    end

    repeat (40) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
